serdes_tx_sched: RTL and testbench

Transmit-side scheduler for the SerDes link: arbitrates two byte-wide requesters round-robin and frames each accepted byte as SYNC, HEADER and DATA. Serializes the frame MSB-first, one bit per clock, onto the link output. Sits between the user-facing input channels and the pad-level serial output in the top-level wrapper.

---
 rtl/serdes_tx_sched_if.sv | 27 ++
 rtl/serdes_tx_sched.sv | 173 +++++++++++++++++
 tb/tb_serdes_tx_sched.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdes_tx_sched_if.sv
// serdes_tx_sched_if
//   Request-side bundle for the transmit scheduler: two byte-wide
//   valid/ready channels.
//   master : requester side (drives valid/data, receives ready)
//   slave  : scheduler side (receives valid/data, drives ready)
interface serdes_tx_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_data,
    input  req0_ready,
    output req1_valid, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_data,
    output req0_ready,
    input  req1_valid, req1_data,
    output req1_ready
  );
endinterface

// File: rtl/serdes_tx_sched.sv
// serdes_tx_sched
//   Round-robin arbiter over two byte channels. Each accepted byte is
//   framed as SYNC, HEADER {ch_id, seq} and DATA and shifted out MSB-first,
//   one bit per clock.
//
//   Optional feature macro: SERDES_PARITY_EN
//     defined   : a one-bit PAR state follows DATA carrying even parity
//                 over {HEADER, DATA}; frames are 25 bits
//     undefined : 24-bit frames
//
//   Ports
//     clk        : single clock, rising edge
//     rst        : synchronous active-high reset
//     en_i       : grant enable; an in-flight frame always completes
//     req_if     : slave modport, two valid/data/ready channels
//     tx_bit_o   : serial data, MSB-first
//     tx_frame_o : high while tx_bit_o carries frame bits
//     busy_o     : high from the accept cycle through the last frame bit
//
//   state | meaning
//   IDLE  | no frame on the line, accept point
//   SYNC  | shifting SYNC_WORD
//   HDR   | shifting {ch_id, seq}
//   DATA  | shifting the latched byte
//   PAR   | parity bit (SERDES_PARITY_EN only)
module serdes_tx_sched #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int         SEQ_W     = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  serdes_tx_sched_if.slave    req_if,
  output logic                tx_bit_o,
  output logic                tx_frame_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
`ifdef SERDES_PARITY_EN
    ST_DATA,
    ST_PAR
`else
    ST_DATA
`endif
  } state_t;

`ifdef SERDES_PARITY_EN
  localparam state_t LAST_ST = ST_PAR;
`else
  localparam state_t LAST_ST = ST_DATA;
`endif

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [SEQ_W-1:0] seq_q;
  logic             last_grant_q;
  logic [7:0]       hdr_q;
  logic [7:0]       data_q;
  logic             tx_bit_q;
  logic             tx_frame_q;

  logic       acc_pt;
  logic       any_valid;
  logic       gnt;
  logic       accept;
  logic [2:0] cnt_m1;
`ifdef SERDES_PARITY_EN
  logic       par;
`endif

  always_comb begin
    acc_pt    = (state_q == ST_IDLE) || ((state_q == LAST_ST) && (cnt_q == 3'd0));
    any_valid = req_if.req0_valid | req_if.req1_valid;
    // On a tie the channel not served last wins; otherwise the lone requester.
    gnt       = (req_if.req0_valid && req_if.req1_valid) ? ~last_grant_q : req_if.req1_valid;
    accept    = acc_pt & en_i & any_valid & ~rst;
    cnt_m1    = cnt_q - 3'd1;
`ifdef SERDES_PARITY_EN
    par       = ^{hdr_q, data_q};
`endif
  end

  assign req_if.req0_ready = accept & ~gnt;
  assign req_if.req1_ready = accept & gnt;
  assign busy_o            = (state_q != ST_IDLE) | accept;
  assign tx_bit_o          = tx_bit_q;
  assign tx_frame_o        = tx_frame_q;

  // Registered outputs are loaded with the bit of the state being entered,
  // so tx_bit_q always corresponds to (state_q, cnt_q).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      seq_q        <= '0;
      last_grant_q <= 1'b1;
      hdr_q        <= 8'h00;
      data_q       <= 8'h00;
      tx_bit_q     <= 1'b0;
      tx_frame_q   <= 1'b0;
    end else if (accept) begin
      state_q      <= ST_SYNC;
      cnt_q        <= 3'd7;
      tx_bit_q     <= SYNC_WORD[7];
      tx_frame_q   <= 1'b1;
      hdr_q        <= {gnt, seq_q};
      data_q       <= gnt ? req_if.req1_data : req_if.req0_data;
      seq_q        <= seq_q + 1'b1;
      last_grant_q <= gnt;
    end else begin
      // Down-counter wraps 0 -> 7 on its own when moving to the next byte.
      cnt_q <= cnt_m1;
      case (state_q)
        ST_IDLE: begin
          cnt_q      <= 3'd0;
          tx_bit_q   <= 1'b0;
          tx_frame_q <= 1'b0;
        end
        ST_SYNC: begin
          if (cnt_q == 3'd0) begin
            state_q  <= ST_HDR;
            tx_bit_q <= hdr_q[7];
          end else begin
            tx_bit_q <= SYNC_WORD[cnt_m1];
          end
        end
        ST_HDR: begin
          if (cnt_q == 3'd0) begin
            state_q  <= ST_DATA;
            tx_bit_q <= data_q[7];
          end else begin
            tx_bit_q <= hdr_q[cnt_m1];
          end
        end
        ST_DATA: begin
          if (cnt_q == 3'd0) begin
`ifdef SERDES_PARITY_EN
            state_q    <= ST_PAR;
            cnt_q      <= 3'd0;
            tx_bit_q   <= par;
`else
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            tx_bit_q   <= 1'b0;
            tx_frame_q <= 1'b0;
`endif
          end else begin
            tx_bit_q <= data_q[cnt_m1];
          end
        end
`ifdef SERDES_PARITY_EN
        ST_PAR: begin
          state_q    <= ST_IDLE;
          cnt_q      <= 3'd0;
          tx_bit_q   <= 1'b0;
          tx_frame_q <= 1'b0;
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= 3'd0;
          tx_bit_q   <= 1'b0;
          tx_frame_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// tb_serdes_tx_sched
//   Drives randomized and directed traffic into serdes_tx_sched and checks
//   every output on every cycle against a queue-of-bits reference model.
module tb_serdes_tx_sched;
`ifdef SERDES_PARITY_EN
  localparam int FLEN = 25;
`else
  localparam int FLEN = 24;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic tx_bit, tx_frame, busy;

  always #5 clk = ~clk;

  serdes_tx_sched_if req_if();

  serdes_tx_sched dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .req_if     (req_if),
    .tx_bit_o   (tx_bit),
    .tx_frame_o (tx_frame),
    .busy_o     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The expected line is a queue of pending frame bits; its head is what
  // must be on tx_bit now. Accepts are possible while at most one bit remains.
  bit         mq[$];
  bit         m_last;
  logic [6:0] m_seq;
  bit         armed = 1'b0;
  int         m_nacc = 0;
  bit         m_acc0, m_acc1;
  bit         pa, pg, ca, cg;
  logic [7:0] mh, md;

  function automatic bit m_accept();
    return !rst && en && (req_if.req0_valid || req_if.req1_valid) && (mq.size() <= 1);
  endfunction

  function automatic bit m_gnt();
    if (req_if.req0_valid && req_if.req1_valid) return !m_last;
    return req_if.req1_valid;
  endfunction

  always @(posedge clk) begin
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
    if (rst) begin
      mq.delete();
      m_seq = 7'd0;
      m_last = 1'b1;
      armed = 1'b1;
    end else if (armed) begin
      pa = m_accept();
      pg = m_gnt();
      if (mq.size() > 0) void'(mq.pop_front());
      if (pa) begin
        mh = {pg, m_seq};
        md = pg ? req_if.req1_data : req_if.req0_data;
        for (int i = 7; i >= 0; i--) mq.push_back(8'hA5 >> i & 1);
        for (int i = 7; i >= 0; i--) mq.push_back(mh[i]);
        for (int i = 7; i >= 0; i--) mq.push_back(md[i]);
`ifdef SERDES_PARITY_EN
        mq.push_back(^{mh, md});
`endif
        m_seq  = m_seq + 7'd1;
        m_last = pg;
        m_nacc++;
        if (pg) m_acc1 = 1'b1;
        else    m_acc0 = 1'b1;
      end
    end
  end

  // Single compare process: all outputs, every cycle after the first reset.
  always @(negedge clk) begin
    if (armed) begin
      ca = m_accept();
      cg = m_gnt();
      chk("tx_frame", {31'd0, tx_frame}, {31'd0, mq.size() > 0});
      chk("tx_bit",   {31'd0, tx_bit},   {31'd0, (mq.size() > 0) ? mq[0] : 1'b0});
      chk("busy",     {31'd0, busy},     {31'd0, (mq.size() > 0) || ca});
      chk("ready0",   {31'd0, req_if.req0_ready}, {31'd0, ca && !cg});
      chk("ready1",   {31'd0, req_if.req1_ready}, {31'd0, ca && cg});
    end
  end

  // ---------------- frame capture ----------------
  logic [FLEN-1:0] cap_sh;
  int              cap_n = 0;
  logic [FLEN-1:0] frames[$];

  always @(negedge clk) begin
    if (!tx_frame) cap_n = 0;
    else begin
      cap_sh = {cap_sh[FLEN-2:0], tx_bit};
      cap_n++;
      if (cap_n == FLEN) begin
        frames.push_back(cap_sh);
        cap_n = 0;
      end
    end
  end

  function automatic logic [FLEN-1:0] fr(input int k);
    if (k < frames.size()) return frames[k];
    return '1;
  endfunction

  function automatic logic [7:0] hdr_of(input logic [FLEN-1:0] f);
    return f[FLEN-9 -: 8];
  endfunction

  function automatic logic [7:0] dat_of(input logic [FLEN-1:0] f);
    return f[FLEN-17 -: 8];
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_if.req0_valid = 1'b0;
    req_if.req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    frames.delete();
  endtask

  task automatic drain();
    repeat (FLEN + 3) tick();
  endtask

  task automatic wait_acc(input int n, input int budget);
    int start;
    start = m_nacc;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (m_nacc - start >= n) return;
    end
    chk("wait_acc_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int ch, input logic [7:0] d);
    if (ch == 0) begin req_if.req0_valid = 1'b1; req_if.req0_data = d; end
    else         begin req_if.req1_valid = 1'b1; req_if.req1_data = d; end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ch == 0 && m_acc0) begin req_if.req0_valid = 1'b0; return; end
      if (ch == 1 && m_acc1) begin req_if.req1_valid = 1'b0; return; end
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  logic [FLEN-1:0] lit_single;

  initial begin
    req_if.req0_valid = 1'b0; req_if.req0_data = 8'h00;
    req_if.req1_valid = 1'b0; req_if.req1_data = 8'h00;
`ifdef SERDES_PARITY_EN
    lit_single = {24'hA5003C, 1'b0};
`else
    lit_single = 24'hA5003C;
`endif

    // Single request
    do_reset();
    en = 1'b1;
    req_if.req0_valid = 1'b1; req_if.req0_data = 8'h3C;
    @(negedge clk);
    chk("A_ready0_at_T", {31'd0, req_if.req0_ready}, 32'd1);
    chk("A_busy_at_T",   {31'd0, busy}, 32'd1);
    tick();
    req_if.req0_valid = 1'b0;
    drain();
    chk("A_nframes", frames.size(), 32'd1);
    chk("A_frame_bits", fr(0), lit_single);
    chk("A_idle_frame", {31'd0, tx_frame}, 32'd0);
    chk("A_idle_busy",  {31'd0, busy}, 32'd0);

    // Tie and round-robin
    do_reset();
    req_if.req0_valid = 1'b1; req_if.req0_data = 8'h11;
    req_if.req1_valid = 1'b1; req_if.req1_data = 8'h22;
    wait_acc(3, 200);
    req_if.req0_valid = 1'b0; req_if.req1_valid = 1'b0;
    drain();
    chk("B_nframes", frames.size(), 32'd3);
    chk("B_hdr0", hdr_of(fr(0)), 8'h00);
    chk("B_hdr1", hdr_of(fr(1)), 8'h81);
    chk("B_hdr2", hdr_of(fr(2)), 8'h02);
    chk("B_dat0", dat_of(fr(0)), 8'h11);
    chk("B_dat1", dat_of(fr(1)), 8'h22);

    // Sequence wrap
    do_reset();
    req_if.req0_valid = 1'b1; req_if.req0_data = 8'($urandom);
    wait_acc(129, 129 * FLEN + 50);
    req_if.req0_valid = 1'b0;
    drain();
    chk("C_nframes", frames.size(), 32'd129);
    chk("C_hdr128", hdr_of(fr(127)), 8'h7F);
    chk("C_hdr129", hdr_of(fr(128)), 8'h00);

    // en gating mid-frame
    do_reset();
    req_if.req1_valid = 1'b1; req_if.req1_data = 8'h96;
    tick();
    repeat (4) tick();
    en = 1'b0;
    repeat (FLEN) tick();
    @(negedge clk);
    chk("D_idle_frame", {31'd0, tx_frame}, 32'd0);
    chk("D_no_ready1",  {31'd0, req_if.req1_ready}, 32'd0);
    tick();
    en = 1'b1;
    @(negedge clk);
    chk("D_reaccept", {31'd0, req_if.req1_ready}, 32'd1);
    tick();
    req_if.req1_valid = 1'b0;
    drain();
    chk("D_nframes", frames.size(), 32'd2);
    chk("D_hdr0", hdr_of(fr(0)), 8'h80);
    chk("D_hdr1", hdr_of(fr(1)), 8'h81);

    // Reset mid-frame
    do_reset();
    send(0, 8'h5A);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("E_frame", {31'd0, tx_frame}, 32'd0);
    chk("E_busy",  {31'd0, busy}, 32'd0);
    chk("E_rdy0",  {31'd0, req_if.req0_ready}, 32'd0);
    chk("E_rdy1",  {31'd0, req_if.req1_ready}, 32'd0);
    tick();
    frames.delete();
    req_if.req0_valid = 1'b1; req_if.req0_data = 8'h33;
    req_if.req1_valid = 1'b1; req_if.req1_data = 8'h44;
    wait_acc(2, 200);
    req_if.req0_valid = 1'b0; req_if.req1_valid = 1'b0;
    drain();
    chk("E_hdr0", hdr_of(fr(0)), 8'h00);
    chk("E_dat0", dat_of(fr(0)), 8'h33);
    chk("E_hdr1", hdr_of(fr(1)), 8'h81);

`ifdef SERDES_PARITY_EN
    // Parity bit
    do_reset();
    send(0, 8'h3C);
    send(0, 8'h3D);
    drain();
    chk("G_par_3C", {31'd0, fr(0)[0]}, 32'd0);
    chk("G_hdr_3D", hdr_of(fr(1)), 8'h01);
    chk("G_par_3D", {31'd0, fr(1)[0]}, 32'd0);
    do_reset();
    send(1, 8'h01);
    drain();
    chk("G_hdr_01", hdr_of(fr(0)), 8'h80);
    chk("G_par_01", {31'd0, fr(0)[0]}, 32'd0);
    do_reset();
    send(0, 8'h07);
    drain();
    chk("G_par_07", {31'd0, fr(0)[0]}, 32'd1);
`endif

    // Randomized traffic, enable and occasional reset
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if (!req_if.req0_valid || m_acc0) begin
        req_if.req0_valid = ($urandom_range(0, 2) != 0);
        req_if.req0_data  = 8'($urandom);
      end
      if (!req_if.req1_valid || m_acc1) begin
        req_if.req1_valid = ($urandom_range(0, 2) != 0);
        req_if.req1_data  = 8'($urandom);
      end
      en  = ($urandom_range(0, 15) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    en  = 1'b1;
    req_if.req0_valid = 1'b0; req_if.req1_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
